rgmii_rx_speed_adapter: RTL and testbench

RGMII_RX_SPEED_ADAPTER -- requirements
Module: rgmii_rx_speed_adapter

---
 rtl/rgmii_rx_speed_adapter.sv | 171 +++++++++++++++++
 tb/tb_rgmii_rx_speed_adapter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_speed_adapter.sv
// RGMII receive speed adapter: DDR nibble pairs to a GMII byte stream
// with 10/100 nibble assembly and filtered in-band link status.
module rgmii_rx_speed_adapter #(
    parameter int INBAND_FILTER = 4,
    parameter     SPEED_AUTO    = "TRUE"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_d1,
    input  logic [3:0] in_d2,
    input  logic       in_ctl1,
    input  logic       in_ctl2,
    input  logic [1:0] speed,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_valid,
    output logic       status_link,
    output logic       status_duplex,
    output logic [1:0] status_speed,
    output logic       status_valid,
    output logic       odd_nibble,
    output logic [1:0] eff_speed
);

    localparam bit       AUTO = (SPEED_AUTO == "TRUE");
    localparam bit [3:0] FILT = 4'(INBAND_FILTER);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t     state, state_nx;
    logic       dv_in, er_in, inband, ib_bad;
    logic [3:0] prev, cnt, cnt_nx;
    logic [3:0] low, low_nx;
    logic       sticky, sticky_nx, toggle, toggle_nx;
    logic [7:0] rxd_nx;
    logic       dv_nx, er_nx, valid_nx, odd_nx;
    logic [1:0] target;
    logic       gig, spd_upd, spd_chg;

    assign dv_in   = in_ctl1;
    assign er_in   = in_ctl1 ^ in_ctl2;
    assign inband  = !in_ctl1 && !in_ctl2;
    assign ib_bad  = (in_d1[2:1] == 2'b11);
    assign cnt_nx  = (in_d1 != prev) ? 4'd1 :
                     (cnt == 4'hf)   ? cnt  : cnt + 4'd1;
    assign gig     = eff_speed[1];
    assign target  = (AUTO && status_link) ? status_speed : speed;
    assign spd_upd = !dv_in && (state == IDLE);
    assign spd_chg = spd_upd && (target != eff_speed);

    always_comb begin
        state_nx  = state;
        low_nx    = low;
        sticky_nx = sticky;
        toggle_nx = toggle;
        rxd_nx    = gmii_rxd;
        dv_nx     = gmii_rx_dv;
        er_nx     = gmii_rx_er;
        valid_nx  = 1'b0;
        odd_nx    = 1'b0;
        if (gig) begin
            valid_nx  = 1'b1;
            rxd_nx    = {in_d2, in_d1};
            dv_nx     = dv_in;
            er_nx     = er_in;
            state_nx  = IDLE;
            toggle_nx = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    toggle_nx = !toggle;
                    if (dv_in) begin
                        low_nx    = in_d1;
                        sticky_nx = er_in;
                        state_nx  = HIGH;
                    end else if (toggle) begin
                        valid_nx = 1'b1;
                        rxd_nx   = 8'h00;
                        dv_nx    = 1'b0;
                        er_nx    = 1'b0;
                    end
                end
                HIGH: begin
                    valid_nx = 1'b1;
                    dv_nx    = 1'b1;
                    if (dv_in) begin
                        rxd_nx    = {in_d1, low};
                        er_nx     = sticky | er_in;
                        sticky_nx = 1'b0;
                        state_nx  = LOW;
                    end else begin
                        // frame ended on a half byte: flush it flagged bad
                        rxd_nx   = {4'h0, low};
                        er_nx    = 1'b1;
                        odd_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end
                LOW: begin
                    if (dv_in) begin
                        low_nx    = in_d1;
                        sticky_nx = er_in;
                        state_nx  = HIGH;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        if (spd_chg) begin
            state_nx  = IDLE;
            toggle_nx = 1'b0;
            valid_nx  = 1'b0;
            odd_nx    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            low           <= 4'h0;
            sticky        <= 1'b0;
            toggle        <= 1'b0;
            gmii_rxd      <= 8'h00;
            gmii_rx_dv    <= 1'b0;
            gmii_rx_er    <= 1'b0;
            gmii_rx_valid <= 1'b0;
            odd_nibble    <= 1'b0;
            eff_speed     <= speed;
        end else begin
            state         <= state_nx;
            low           <= low_nx;
            sticky        <= sticky_nx;
            toggle        <= toggle_nx;
            gmii_rxd      <= rxd_nx;
            gmii_rx_dv    <= dv_nx;
            gmii_rx_er    <= er_nx;
            gmii_rx_valid <= valid_nx;
            odd_nibble    <= odd_nx;
            if (spd_upd) eff_speed <= target;
        end
    end

    // in-band status filter; only idle (ctl1=ctl2=0) cycles carry a sample
    always_ff @(posedge clk) begin
        if (rst) begin
            prev          <= 4'h0;
            cnt           <= 4'h0;
            status_link   <= 1'b0;
            status_speed  <= 2'b00;
            status_duplex <= 1'b0;
            status_valid  <= 1'b0;
        end else if (inband) begin
            prev <= in_d1;
            if (ib_bad) begin
                cnt <= 4'h0;
            end else begin
                cnt <= cnt_nx;
                if (cnt_nx == FILT) begin
                    status_link   <= in_d1[0];
                    status_speed  <= in_d1[2:1];
                    status_duplex <= in_d1[3];
                    status_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_speed_adapter.sv
// Directed bench for rgmii_rx_speed_adapter: 1G, 100M, 10M paths,
// in-band filter, deferred speed change and mid-frame reset.
module tb_rgmii_rx_speed_adapter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_d1 = 4'h0;
    logic [3:0] in_d2 = 4'h0;
    logic       in_ctl1 = 1'b0;
    logic       in_ctl2 = 1'b0;
    logic [1:0] speed = 2'b10;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv, gmii_rx_er, gmii_rx_valid;
    logic       status_link, status_duplex, status_valid;
    logic [1:0] status_speed;
    logic       odd_nibble;
    logic [1:0] eff_speed;

    int checks = 0;
    int errors = 0;

    rgmii_rx_speed_adapter #(.INBAND_FILTER(4), .SPEED_AUTO("TRUE")) dut (
        .clk(clk), .rst(rst),
        .in_d1(in_d1), .in_d2(in_d2),
        .in_ctl1(in_ctl1), .in_ctl2(in_ctl2),
        .speed(speed),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
        .gmii_rx_er(gmii_rx_er), .gmii_rx_valid(gmii_rx_valid),
        .status_link(status_link), .status_duplex(status_duplex),
        .status_speed(status_speed), .status_valid(status_valid),
        .odd_nibble(odd_nibble), .eff_speed(eff_speed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] b,
                        input logic c1, input logic c2);
        in_d1   = a;
        in_d2   = b;
        in_ctl1 = c1;
        in_ctl2 = c2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset in 1G
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_valid", 8'(gmii_rx_valid), 8'h0);
        chk("rst_rxd", gmii_rxd, 8'h00);
        chk("rst_dv", 8'(gmii_rx_dv), 8'h0);
        chk("rst_er", 8'(gmii_rx_er), 8'h0);
        chk("rst_odd", 8'(odd_nibble), 8'h0);
        chk("rst_sv", 8'(status_valid), 8'h0);
        chk("rst_eff", 8'(eff_speed), 8'h2);
        rst = 1'b0;

        // 1G byte path
        step(4'h5, 4'hA, 1, 1);
        chk("g_rxd", gmii_rxd, 8'hA5);
        chk("g_dv", 8'(gmii_rx_dv), 8'h1);
        chk("g_er", 8'(gmii_rx_er), 8'h0);
        chk("g_valid", 8'(gmii_rx_valid), 8'h1);
        step(4'h3, 4'hC, 1, 0);
        chk("g_rxd2", gmii_rxd, 8'hC3);
        chk("g_er2", 8'(gmii_rx_er), 8'h1);
        step(0, 0, 0, 0);
        chk("g_idle_dv", 8'(gmii_rx_dv), 8'h0);
        chk("g_idle_v", 8'(gmii_rx_valid), 8'h1);

        // switch to 100M: toggle restarts, first idle strobe 2 cycles later
        speed = 2'b01;
        step(0, 0, 0, 0);
        chk("c_eff", 8'(eff_speed), 8'h1);
        chk("c_v0", 8'(gmii_rx_valid), 8'h0);
        step(0, 0, 0, 0);
        chk("c_v1", 8'(gmii_rx_valid), 8'h0);
        step(0, 0, 0, 0);
        chk("c_v2", 8'(gmii_rx_valid), 8'h1);
        chk("c_rxd", gmii_rxd, 8'h00);

        // 100M frame 5,5,D,5
        step(4'h5, 0, 1, 1);
        chk("m_v0", 8'(gmii_rx_valid), 8'h0);
        step(4'h5, 0, 1, 1);
        chk("m_rxd1", gmii_rxd, 8'h55);
        chk("m_v1", 8'(gmii_rx_valid), 8'h1);
        chk("m_dv1", 8'(gmii_rx_dv), 8'h1);
        chk("m_er1", 8'(gmii_rx_er), 8'h0);
        step(4'hD, 0, 1, 1);
        chk("m_v2", 8'(gmii_rx_valid), 8'h0);
        chk("m_hold", gmii_rxd, 8'h55);
        step(4'h5, 0, 1, 1);
        chk("m_rxd2", gmii_rxd, 8'h5D);
        chk("m_v3", 8'(gmii_rx_valid), 8'h1);
        step(0, 0, 0, 0);
        chk("m_v4", 8'(gmii_rx_valid), 8'h0);
        chk("m_odd", 8'(odd_nibble), 8'h0);
        step(0, 0, 0, 0);
        chk("m_idle_v", 8'(gmii_rx_valid), 8'h1);
        chk("m_idle_dv", 8'(gmii_rx_dv), 8'h0);
        step(0, 0, 0, 0);
        chk("m_idle_v2", 8'(gmii_rx_valid), 8'h0);

        // 10M odd frame 1,2,3
        speed = 2'b00;
        step(0, 0, 0, 0);
        chk("t_eff", 8'(eff_speed), 8'h0);
        step(4'h1, 0, 1, 1);
        step(4'h2, 0, 1, 1);
        chk("t_rxd1", gmii_rxd, 8'h21);
        chk("t_er1", 8'(gmii_rx_er), 8'h0);
        step(4'h3, 0, 1, 1);
        step(0, 0, 0, 0);
        chk("t_rxd2", gmii_rxd, 8'h03);
        chk("t_er2", 8'(gmii_rx_er), 8'h1);
        chk("t_dv2", 8'(gmii_rx_dv), 8'h1);
        chk("t_odd", 8'(odd_nibble), 8'h1);
        step(0, 0, 0, 0);
        chk("t_odd_end", 8'(odd_nibble), 8'h0);

        // sticky error on the low nibble
        step(4'h7, 0, 1, 0);
        step(4'h8, 0, 1, 1);
        chk("s_rxd", gmii_rxd, 8'h87);
        chk("s_er", 8'(gmii_rx_er), 8'h1);
        step(0, 0, 0, 0);

        // reset while a low nibble is pending
        step(4'h9, 0, 1, 1);
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        chk("r_valid", 8'(gmii_rx_valid), 8'h0);
        chk("r_rxd", gmii_rxd, 8'h00);
        chk("r_dv", 8'(gmii_rx_dv), 8'h0);
        chk("r_er", 8'(gmii_rx_er), 8'h0);
        chk("r_odd", 8'(odd_nibble), 8'h0);
        chk("r_eff", 8'(eff_speed), 8'h0);
        step(0, 0, 0, 0);
        chk("r_valid2", 8'(gmii_rx_valid), 8'h0);
        chk("r_odd2", 8'(odd_nibble), 8'h0);

        // in-band filter: link up, 1G, full duplex
        step(4'hD, 0, 0, 0);
        step(4'hD, 0, 0, 0);
        step(4'hD, 0, 0, 0);
        chk("f_sv3", 8'(status_valid), 8'h0);
        step(4'hD, 0, 0, 0);
        chk("f_sv4", 8'(status_valid), 8'h1);
        chk("f_link", 8'(status_link), 8'h1);
        chk("f_spd", 8'(status_speed), 8'h2);
        chk("f_dup", 8'(status_duplex), 8'h1);
        step(4'hD, 0, 0, 0);
        chk("f_eff", 8'(eff_speed), 8'h2);

        // in-band drop to 10M
        for (int i = 0; i < 5; i++) step(4'h1, 0, 0, 0);
        chk("b_eff10", 8'(eff_speed), 8'h0);
        chk("b_dup", 8'(status_duplex), 8'h0);

        // 100M status completes at frame end; eff waits for IDLE
        step(4'h3, 0, 0, 0);
        step(4'h3, 0, 0, 0);
        step(4'h3, 0, 0, 0);
        step(4'h4, 0, 1, 1);
        chk("b_eff_f", 8'(eff_speed), 8'h0);
        step(4'h6, 0, 1, 1);
        chk("b_rxd", gmii_rxd, 8'h64);
        step(4'h3, 0, 0, 0);
        chk("b_sspd", 8'(status_speed), 8'h1);
        chk("b_eff_e", 8'(eff_speed), 8'h0);
        step(4'h3, 0, 0, 0);
        chk("b_eff100", 8'(eff_speed), 8'h1);

        // speed input change mid-frame is deferred
        rst = 1'b1;
        speed = 2'b00;
        step(0, 0, 0, 0);
        rst = 1'b0;
        step(4'h1, 0, 1, 1);
        speed = 2'b01;
        step(4'h2, 0, 1, 1);
        chk("d_eff1", 8'(eff_speed), 8'h0);
        step(0, 0, 0, 0);
        chk("d_eff2", 8'(eff_speed), 8'h0);
        step(0, 0, 0, 0);
        chk("d_eff3", 8'(eff_speed), 8'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
